// File: rtl/srv_mem_line_fill.sv
// srv_mem_line_fill
//   Fills one 4-word (128-bit) instruction-cache line from a combinational
//   reset ROM. A level request in IDLE latches the line-aligned base. Four
//   FILL beats then read base+0..3, and a single-cycle response is given in
//   RESP.
//
//   Optional build macro SRV_MEM_LATENCY_EN adds a WAIT state in front of
//   FILL. WAIT holds for LATENCY cycles (0..255) to model slow external
//   memory. Without the macro, LATENCY is ignored and the request-to-response
//   latency is fixed at 5 cycles.
//
// Ports
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   ext_addr_i  : requested word address; bits [1:0] ignored
//   ext_req_i   : level request, held until ext_rsp_o
//   ext_rsp_o   : one-cycle pulse, ext_data_o holds the filled line
//   ext_data_o  : filled line, word k in bits [32k+31:32k]
//   rom_addr_o  : word address to the ROM
//   rom_data_i  : ROM word at rom_addr_o, same cycle
//   busy_o      : high whenever the FSM is not in IDLE
//   fill_cnt_o  : saturating count of completed line fills
module srv_mem_line_fill #(
  parameter int unsigned LATENCY = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  ext_addr_i,
  input  logic         ext_req_i,
  output logic         ext_rsp_o,
  output logic [127:0] ext_data_o,
  output logic [31:0]  rom_addr_o,
  input  logic [31:0]  rom_data_i,
  output logic         busy_o,
  output logic [31:0]  fill_cnt_o
);

  if (LATENCY > 255) begin : g_lat_chk
    $error("srv_mem_line_fill: LATENCY must be in 0..255");
  end

`ifdef SRV_MEM_LATENCY_EN
  typedef enum logic [1:0] {IDLE, WAIT, FILL, RESP} state_t;
  localparam logic [7:0] LAT8 = 8'(LATENCY);
  logic [7:0] wait_q;
`else
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
`endif

  state_t       state_q, state_d;
  logic [31:2]  base_q;     // only the line-aligned part is kept
  logic [1:0]   beat_q;
  logic [127:0] data_q;
  logic [31:0]  fill_cnt_q;

  // The low address bits select a word inside the line and are re-generated per beat.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ext_addr_i[1:0];

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ext_req_i) begin
`ifdef SRV_MEM_LATENCY_EN
          state_d = (LAT8 != 8'd0) ? WAIT : FILL;
`else
          state_d = FILL;
`endif
        end
      end
`ifdef SRV_MEM_LATENCY_EN
      WAIT: if (wait_q == LAT8 - 8'd1) state_d = FILL;
`endif
      FILL: if (beat_q == 2'd3) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat addresses only replace bits [1:0], so a fill never carries into the next line.
  always_comb begin
    rom_addr_o = {base_q, 2'b00};
    case (state_q)
      IDLE:    rom_addr_o = {ext_addr_i[31:2], 2'b00};
      FILL:    rom_addr_o = {base_q, beat_q};
      default: rom_addr_o = {base_q, 2'b00};
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign ext_rsp_o  = (state_q == RESP);
  assign ext_data_o = data_q;
  assign fill_cnt_o = fill_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      beat_q     <= '0;
      data_q     <= '0;
      fill_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ext_req_i) begin
            base_q <= ext_addr_i[31:2];
            beat_q <= 2'd0;
          end
        end
        FILL: begin
          // Words land one per beat; ext_rsp_o only rises once all four are in.
          data_q[32*beat_q +: 32] <= rom_data_i;
          beat_q                  <= beat_q + 2'd1;
        end
        RESP: begin
          if (fill_cnt_q != 32'hFFFF_FFFF) fill_cnt_q <= fill_cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SRV_MEM_LATENCY_EN
  // Counts cycles spent in WAIT. It is cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_q <= '0;
    else if (state_q == WAIT) wait_q <= wait_q + 8'd1;
    else                     wait_q <= '0;
  end
`endif

endmodule
